// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared encodings and default grid constants for the snake engine
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_ALIVE,
        ST_MOVE,
        ST_COMMIT,
        ST_DEAD
    } state_t;

    localparam int DEF_GRID_W   = 32;
    localparam int DEF_GRID_H   = 24;
    localparam int DEF_MAX_LEN  = 64;
    localparam int DEF_INIT_LEN = 3;

    // UP<->DOWN and RIGHT<->LEFT differ only in bit 0
    function automatic dir_t opposite(input dir_t d);
        return dir_t'(d ^ 2'b01);
    endfunction

endpackage

// File: rtl/snake_ring.sv
// rtl/snake_ring.sv - circular buffer of body cells, head pushed in, tail popped out
module snake_ring #(
    parameter int  XW      = 5,
    parameter int  YW      = 5,
    parameter int  MAX_LEN = 64,
    localparam int PW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          push,
    input  logic [XW-1:0] push_x,
    input  logic [YW-1:0] push_y,
    input  logic          pop,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [XW-1:0] tail_x,
    output logic [YW-1:0] tail_y
);

    logic [XW-1:0] mem_x [MAX_LEN];
    logic [YW-1:0] mem_y [MAX_LEN];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] last_ptr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_LEN - 1)) ? '0 : p + 1'b1;
    endfunction

    assign last_ptr = (wr_ptr == '0) ? PW'(MAX_LEN - 1) : wr_ptr - 1'b1;
    assign head_x   = mem_x[last_ptr];
    assign head_y   = mem_y[last_ptr];
    assign tail_x   = mem_x[rd_ptr];
    assign tail_y   = mem_y[rd_ptr];

    // Pointer update; a full ring pushes onto the slot the tail is leaving
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    // Cell storage, no reset needed since pointers gate validity
    always_ff @(posedge clk) begin
        if (push) begin
            mem_x[wr_ptr] <= push_x;
            mem_y[wr_ptr] <= push_y;
        end
    end

endmodule

// File: rtl/snake_engine.sv
// rtl/snake_engine.sv - snake body engine (ring + occupancy bitmap); SNAKE_WRAP_EN wraps the head at grid edges
module snake_engine
    import snake_pkg::*;
#(
    parameter int  GRID_W   = DEF_GRID_W,
    parameter int  GRID_H   = DEF_GRID_H,
    parameter int  MAX_LEN  = DEF_MAX_LEN,
    parameter int  INIT_LEN = DEF_INIT_LEN,
    localparam int XW       = $clog2(GRID_W),
    localparam int YW       = $clog2(GRID_H),
    localparam int LW       = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          step,
    input  logic [1:0]    direction_in,
    input  logic [XW-1:0] food_x,
    input  logic [YW-1:0] food_y,
    input  logic [XW-1:0] q_x,
    input  logic [YW-1:0] q_y,
    output logic          q_hit,
    output logic [XW-1:0] head_x,
    output logic [YW-1:0] head_y,
    output logic [1:0]    cur_dir,
    output logic [LW-1:0] length,
    output logic          busy,
    output logic          done,
    output logic          get_food,
    output logic          hit_boundary,
    output logic          hit_self
);

    state_t        state;
    state_t        state_n;
    dir_t          dir_q;
    logic [LW-1:0] init_cnt;
    logic [XW-1:0] init_x;
    logic [YW-1:0] init_y;

    logic          clear;
    logic          init_push;
    logic          take_step;
    logic          commit;
    logic          die_bnd;
    logic          die_self;

    logic [XW-1:0] ring_hx;
    logic [YW-1:0] ring_hy;
    logic [XW-1:0] tail_x;
    logic [YW-1:0] tail_y;
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    logic          oob;
    logic          grow;
    logic          at_max;
    logic          pop_tail;
    logic          self_hit;
    logic          q_in;

    logic [GRID_W-1:0] occ [GRID_H];

    assign init_x   = XW'(GRID_W / 2 - INIT_LEN + 1 + int'(init_cnt));
    assign init_y   = YW'(GRID_H / 2);
    assign cur_dir  = dir_q;
    assign busy     = (state == ST_INIT) || (state == ST_MOVE) || (state == ST_COMMIT);
    assign grow     = (nx == food_x) && (ny == food_y);
    assign at_max   = (length == LW'(MAX_LEN));
    assign pop_tail = !grow || at_max;
    // The tail cell is free to enter only if it is vacated in the same commit
    assign self_hit = occ[ny][nx] && !((nx == tail_x) && (ny == tail_y) && pop_tail);
    assign q_in     = (int'(q_x) < GRID_W) && (int'(q_y) < GRID_H);

    snake_ring #(
        .XW      (XW),
        .YW      (YW),
        .MAX_LEN (MAX_LEN)
    ) u_ring (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .push   (init_push | commit),
        .push_x (init_push ? init_x : nx),
        .push_y (init_push ? init_y : ny),
        .pop    (commit & pop_tail),
        .head_x (ring_hx),
        .head_y (ring_hy),
        .tail_x (tail_x),
        .tail_y (tail_y)
    );

    // Candidate head one cell along the committed direction
    always_comb begin
        nx  = ring_hx;
        ny  = ring_hy;
        oob = 1'b0;
        case (dir_q)
            DIR_UP: begin
                if (ring_hy == '0) begin
`ifdef SNAKE_WRAP_EN
                    ny = YW'(GRID_H - 1);
`else
                    oob = 1'b1;
`endif
                end else begin
                    ny = ring_hy - 1'b1;
                end
            end
            DIR_DOWN: begin
                if (ring_hy == YW'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
                    ny = '0;
`else
                    oob = 1'b1;
`endif
                end else begin
                    ny = ring_hy + 1'b1;
                end
            end
            DIR_RIGHT: begin
                if (ring_hx == XW'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
                    nx = '0;
`else
                    oob = 1'b1;
`endif
                end else begin
                    nx = ring_hx + 1'b1;
                end
            end
            DIR_LEFT: begin
                if (ring_hx == '0) begin
`ifdef SNAKE_WRAP_EN
                    nx = XW'(GRID_W - 1);
`else
                    oob = 1'b1;
`endif
                end else begin
                    nx = ring_hx - 1'b1;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_IDLE;
        else      state <= state_n;
    end

    // Next state and one-cycle control strobes; start overrides everything
    always_comb begin
        state_n   = state;
        clear     = 1'b0;
        init_push = 1'b0;
        take_step = 1'b0;
        commit    = 1'b0;
        die_bnd   = 1'b0;
        die_self  = 1'b0;
        if (start) begin
            state_n = ST_INIT;
            clear   = 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    init_push = 1'b1;
                    if (init_cnt == LW'(INIT_LEN - 1)) state_n = ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (step) begin
                        take_step = 1'b1;
                        state_n   = ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    if (oob) begin
                        die_bnd = 1'b1;
                        state_n = ST_DEAD;
                    end else if (self_hit) begin
                        die_self = 1'b1;
                        state_n  = ST_DEAD;
                    end else begin
                        commit  = 1'b1;
                        state_n = ST_COMMIT;
                    end
                end
                ST_COMMIT: state_n = ST_ALIVE;
                default:   state_n = state;
            endcase
        end
    end

    // Head, length, direction, pulses and sticky death flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_x       <= '0;
            head_y       <= '0;
            length       <= '0;
            init_cnt     <= '0;
            dir_q        <= DIR_RIGHT;
            done         <= 1'b0;
            get_food     <= 1'b0;
            hit_boundary <= 1'b0;
            hit_self     <= 1'b0;
        end else begin
            done     <= 1'b0;
            get_food <= 1'b0;
            if (clear) begin
                length       <= '0;
                init_cnt     <= '0;
                dir_q        <= DIR_RIGHT;
                hit_boundary <= 1'b0;
                hit_self     <= 1'b0;
            end
            if (init_push) begin
                init_cnt <= init_cnt + 1'b1;
                length   <= length + 1'b1;
                head_x   <= init_x;
                head_y   <= init_y;
            end
            if (take_step && (direction_in != opposite(dir_q))) begin
                dir_q <= dir_t'(direction_in);
            end
            if (commit) begin
                head_x   <= nx;
                head_y   <= ny;
                done     <= 1'b1;
                get_food <= grow;
                if (grow && !at_max) length <= length + 1'b1;
            end
            if (die_bnd)  hit_boundary <= 1'b1;
            if (die_self) hit_self     <= 1'b1;
        end
    end

    // Occupancy bitmap; on a commit the head set wins over a tail clear of the same cell
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < GRID_H; r++) occ[r] <= '0;
        end else if (clear) begin
            for (int r = 0; r < GRID_H; r++) occ[r] <= '0;
        end else if (init_push) begin
            occ[init_y][init_x] <= 1'b1;
        end else if (commit) begin
            if (pop_tail) occ[tail_y][tail_x] <= 1'b0;
            occ[ny][nx] <= 1'b1;
        end
    end

    // Registered renderer query, out-of-grid cells read as empty
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_hit <= 1'b0;
        else      q_hit <= q_in ? occ[q_y][q_x] : 1'b0;
    end

endmodule

// File: tb/tb_snake_engine.sv
// tb/tb_snake_engine.sv - randomized self-checking bench for snake_engine against a queue-based body model
module tb_snake_engine;

    localparam int GW = 32;
    localparam int GH = 24;
    localparam int ML = 64;
    localparam int IL = 3;
    localparam int UP = 0, DOWN = 1, RIGHT = 2, LEFT = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       step;
    logic [1:0] direction_in;
    logic [4:0] food_x;
    logic [4:0] food_y;
    logic [4:0] q_x;
    logic [4:0] q_y;
    logic       q_hit;
    logic [4:0] head_x;
    logic [4:0] head_y;
    logic [1:0] cur_dir;
    logic [6:0] length;
    logic       busy;
    logic       done;
    logic       get_food;
    logic       hit_boundary;
    logic       hit_self;

    snake_engine dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .step         (step),
        .direction_in (direction_in),
        .food_x       (food_x),
        .food_y       (food_y),
        .q_x          (q_x),
        .q_y          (q_y),
        .q_hit        (q_hit),
        .head_x       (head_x),
        .head_y       (head_y),
        .cur_dir      (cur_dir),
        .length       (length),
        .busy         (busy),
        .done         (done),
        .get_food     (get_food),
        .hit_boundary (hit_boundary),
        .hit_self     (hit_self)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: body as a queue of cells, tail at index 0, head at the back
    typedef struct {
        int x;
        int y;
    } cell_t;

    cell_t body[$];
    bit    m_alive;
    int    m_hx, m_hy, m_dir;
    bit    m_hb, m_hs;

    function automatic int opp(input int d);
        case (d)
            UP:      return DOWN;
            DOWN:    return UP;
            RIGHT:   return LEFT;
            default: return RIGHT;
        endcase
    endfunction

    function automatic int eff_dir(input int d);
        return (d == opp(m_dir)) ? m_dir : d;
    endfunction

    function automatic bit next_cell(input int d, input int x, input int y, output int nx, output int ny);
        nx = x;
        ny = y;
        case (d)
            UP:      ny = y - 1;
            DOWN:    ny = y + 1;
            RIGHT:   nx = x + 1;
            default: nx = x - 1;
        endcase
`ifdef SNAKE_WRAP_EN
        nx = (nx + GW) % GW;
        ny = (ny + GH) % GH;
        return 1'b0;
`else
        return (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`endif
    endfunction

    function automatic int model_occ(input int x, input int y);
        foreach (body[i]) if (body[i].x == x && body[i].y == y) return 1;
        return 0;
    endfunction

    task automatic model_reset();
        body.delete();
        m_alive = 1'b0;
        m_hx = 0; m_hy = 0; m_dir = RIGHT;
        m_hb = 1'b0; m_hs = 1'b0;
    endtask

    task automatic model_start();
        cell_t c;
        body.delete();
        for (int i = 0; i < IL; i++) begin
            c.x = GW / 2 - IL + 1 + i;
            c.y = GH / 2;
            body.push_back(c);
        end
        m_alive = 1'b1;
        m_hx = GW / 2; m_hy = GH / 2; m_dir = RIGHT;
        m_hb = 1'b0; m_hs = 1'b0;
    endtask

    task automatic model_step(input int d, input int fx, input int fy, output bit e_done, output bit e_food);
        int    nx, ny;
        bit    grow, pop, hit;
        cell_t c;
        e_done = 1'b0;
        e_food = 1'b0;
        if (!m_alive) return;
        m_dir = eff_dir(d);
        if (next_cell(m_dir, m_hx, m_hy, nx, ny)) begin
            m_hb = 1'b1;
            m_alive = 1'b0;
            return;
        end
        grow = (nx == fx) && (ny == fy);
        pop  = !grow || (body.size() == ML);
        hit  = 1'b0;
        for (int i = (pop ? 1 : 0); i < body.size(); i++)
            if (body[i].x == nx && body[i].y == ny) hit = 1'b1;
        if (hit) begin
            m_hs = 1'b1;
            m_alive = 1'b0;
            return;
        end
        c.x = nx;
        c.y = ny;
        body.push_back(c);
        if (pop) void'(body.pop_front());
        m_hx = nx;
        m_hy = ny;
        e_done = 1'b1;
        e_food = grow;
    endtask

    task automatic compare_state();
        check("head_x", 32'(head_x), m_hx);
        check("head_y", 32'(head_y), m_hy);
        check("length", 32'(length), body.size());
        check("cur_dir", 32'(cur_dir), m_dir);
        check("hit_boundary", 32'(hit_boundary), 32'(m_hb));
        check("hit_self", 32'(hit_self), 32'(m_hs));
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start();
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c <= IL; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            check("init_busy", 32'(busy), 1);
        end
        @(posedge clk); #1;
        check("init_end_busy", 32'(busy), 0);
        compare_state();
    endtask

    task automatic do_step(input int d, input int fx, input int fy);
        bit ed, ef, was_alive;
        was_alive = m_alive;
        food_x = 5'(fx);
        food_y = 5'(fy);
        direction_in = 2'(d);
        step = 1'b1;
        model_step(d, fx, fy, ed, ef);
        @(posedge clk); #1;
        step = 1'b0;
        check("move_busy", 32'(busy), 32'(was_alive));
        check("move_done", 32'(done), 0);
        @(posedge clk); #1;
        check("done", 32'(done), 32'(ed));
        check("get_food", 32'(get_food), 32'(ef));
        check("commit_busy", 32'(busy), 32'(ed));
        compare_state();
        @(posedge clk); #1;
        check("done_width", 32'(done), 0);
        check("get_food_width", 32'(get_food), 0);
        check("after_busy", 32'(busy), 0);
    endtask

    task automatic query(input int x, input int y);
        q_x = 5'(x);
        q_y = 5'(y);
        @(posedge clk); #1;
        check("q_hit", 32'(q_hit), model_occ(x, y));
    endtask

    function automatic int serpentine_dir();
        if (m_dir == RIGHT && m_hx == GW - 1) return UP;
        if (m_dir == LEFT && m_hx == 0)       return UP;
        if (m_dir == UP)                      return (m_hx == GW - 1) ? LEFT : RIGHT;
        return m_dir;
    endfunction

    function automatic int square_dir(input int i);
        case (i % 4)
            0:       return UP;
            1:       return LEFT;
            2:       return DOWN;
            default: return RIGHT;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, fx, fy, idx;
        rst = 1'b0; start = 1'b0; step = 1'b0; direction_in = 2'b00;
        food_x = '0; food_y = '0; q_x = '0; q_y = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_state();
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_get_food", 32'(get_food), 0);
        check("reset_q_hit", 32'(q_hit), 0);
        rst = 1'b1;
        @(posedge clk); #1;

        // reset asserted while a move is in flight
        do_start();
        q_x = 5'd16; q_y = 5'd12;
        direction_in = 2'(UP);
        step = 1'b1;
        @(posedge clk); #1;
        step = 1'b0;
        check("mid_move_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        model_reset();
        compare_state();
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_q_hit", 32'(q_hit), 0);
        @(posedge clk); #1;
        rst = 1'b1;
        do_step(UP, 0, 0);

        // init layout and opposite-direction filtering
        do_start();
        query(14, 12);
        query(13, 12);
        query(16, 12);
        do_step(UP, 0, 0);
        check("up_head_y", 32'(head_y), 11);
        query(14, 12);
        do_step(DOWN, 0, 0);
        check("opposite_head_y", 32'(head_y), 10);
        check("opposite_dir", 32'(cur_dir), UP);

        // eating grows the body and keeps the old tail
        do_start();
        do_step(RIGHT, 17, 12);
        check("grow_len", 32'(length), 4);
        query(14, 12);

        // serpentine feeding up to and past MAX_LEN
        do_start();
        for (int s = 0; s < 66; s++) begin
            d = serpentine_dir();
            void'(next_cell(d, m_hx, m_hy, fx, fy));
            do_step(d, fx, fy);
        end
        check("len_saturated", 32'(length), ML);
        query(body[0].x, body[0].y);
        query(16, 12);

        // right edge
        do_start();
        repeat (15) do_step(RIGHT, 0, 0);
        do_step(RIGHT, 0, 0);
`ifdef SNAKE_WRAP_EN
        check("wrap_head_x", 32'(head_x), 0);
        check("wrap_no_flag", 32'(hit_boundary), 0);
`else
        check("edge_flag", 32'(hit_boundary), 1);
        check("edge_head_x", 32'(head_x), 31);
`endif
        do_step(RIGHT, 0, 0);

        // self collision after a U-turn
        do_start();
        do_step(RIGHT, 17, 12);
        do_step(RIGHT, 18, 12);
        do_step(UP, 0, 0);
        do_step(LEFT, 0, 0);
        do_step(DOWN, 0, 0);
        check("self_flag", 32'(hit_self), 1);
        do_step(RIGHT, 0, 0);

        // length 4 chasing its tail around a 2x2 square
        do_start();
        do_step(RIGHT, 17, 12);
        for (int i = 0; i < 8; i++) do_step(square_dir(i), 0, 0);
        check("square_no_hit", 32'(hit_self), 0);
        check("square_len", 32'(length), 4);

        // random walks with food sometimes placed in the path
        for (int ep = 0; ep < 6; ep++) begin
            do_start();
            for (int s = 0; s < 40; s++) begin
                d = $urandom_range(0, 3);
                if (!m_alive) begin
                    do_step(d, 0, 0);
                    break;
                end
                if ($urandom_range(0, 2) == 0) begin
                    if (next_cell(eff_dir(d), m_hx, m_hy, fx, fy)) begin
                        fx = 0;
                        fy = 0;
                    end
                end else begin
                    fx = $urandom_range(0, GW - 1);
                    fy = $urandom_range(0, GH - 1);
                end
                do_step(d, fx, fy);
                idx = $urandom_range(0, body.size() - 1);
                query(body[idx].x, body[idx].y);
                query($urandom_range(0, 31), $urandom_range(0, 31));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
